// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with a one-entry holding buffer
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Three-bit encoding leaves spare codes that fall back to IDLE.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  shreg;
    logic [7:0]  hold_data;
    logic        hold_full;

    logic bit_end;
    logic frame_end;
    logic load_frame;
    logic accept;

    always_comb begin
        bit_end    = (cnt == LAST_CNT);
        frame_end  = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
        load_frame = hold_full && ((state == IDLE) || frame_end);
        accept     = tx_valid && !hold_full;
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // A fresh accept wins over an unload so a waiting byte is never lost.
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end else if (load_frame) begin
                hold_full <= 1'b0;
                tx_ready  <= 1'b1;
            end

            cnt <= bit_end ? '0 : cnt + 16'd1;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                    if (hold_full) begin
                        shreg   <= hold_data;
                        state   <= START;
                        tx_out  <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_out  <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            tx_out   <= 1'b1;
                        end else begin
                            // shreg[0] is the bit now on the line, so the next one is shreg[1].
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_out  <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == LAST_STOP) begin
                            tx_done <= 1'b1;
                            if (hold_full) begin
                                shreg  <= hold_data;
                                state  <= START;
                                tx_out <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    bit_idx <= '0;
                    tx_out  <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized and directed self-checking bench for uart_tx
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB2  = 434;
    localparam int F1    = 10 * CPB;
    localparam int F2    = 11 * CPB2;
    localparam int MAXC  = 40000;

    logic       clk50 = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] d1 = '0, d2 = '0;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic       r1, o1, b1, dn1;
    logic       r2, o2, b2, dn2;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk50(clk50), .rst(rst), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .tx_out(o1), .tx_busy(b1), .tx_done(dn1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .clk50(clk50), .rst(rst), .tx_data(d2), .tx_valid(v2),
        .tx_ready(r2), .tx_out(o2), .tx_busy(b2), .tx_done(dn2)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    bit line1[MAXC];
    bit busy1[MAXC];
    bit done1[MAXC];
    bit rdy1[MAXC];
    bit line2[MAXC];

    always @(negedge clk50) begin
        if (cyc < MAXC) begin
            line1[cyc] = o1;
            busy1[cyc] = b1;
            done1[cyc] = dn1;
            rdy1[cyc]  = r1;
            line2[cyc] = o2;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input bit pass, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (!pass) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    byte unsigned rx_b[$];
    int           rx_s[$];
    bit           rx_ok[$];

    function automatic bit ln(input int w, input int c);
        return (w == 2) ? line2[c] : line1[c];
    endfunction

    function automatic int count_hi(input int sel, input int from, input int to);
        int n = 0;
        for (int c = from; c < to; c++) begin
            case (sel)
                0:       if (busy1[c]) n++;
                1:       if (done1[c]) n++;
                default: if (rdy1[c])  n++;
            endcase
        end
        return n;
    endfunction

    task automatic decode(input int w, input int from, input int to, input int cpb, input int nstop);
        int c, s, nb;
        bit ok, v;
        logic [7:0] dat;
        rx_b.delete(); rx_s.delete(); rx_ok.delete();
        nb = 9 + nstop;
        c  = from;
        while (c < to) begin
            if (ln(w, c) == 1'b0) begin
                s = c; ok = 1'b1; dat = '0;
                for (int b = 0; b < nb; b++) begin
                    if (s + (b + 1) * cpb > to) begin
                        ok = 1'b0;
                        break;
                    end
                    v = ln(w, s + b * cpb);
                    for (int k = 1; k < cpb; k++)
                        if (ln(w, s + b * cpb + k) != v) ok = 1'b0;
                    if (b >= 1 && b <= 8) dat[b-1] = v;
                    else if (b >= 9 && v != 1'b1) ok = 1'b0;
                end
                rx_b.push_back(dat); rx_s.push_back(s); rx_ok.push_back(ok);
                c = s + nb * cpb;
            end else begin
                c++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic send1(input logic [7:0] d, output int acc);
        int k = 0;
        while (r1 !== 1'b1 && k < 2000) begin tick(); k++; end
        chk("send1_ready", r1 === 1'b1, r1, 1'b1);
        d1 = d; v1 = 1'b1;
        tick();
        acc = cyc;
        v1 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        int k = 0;
        while (r2 !== 1'b1 && k < 20000) begin tick(); k++; end
        chk("send2_ready", r2 === 1'b1, r2, 1'b1);
        d2 = d; v2 = 1'b1;
        tick();
        v2 = 1'b0;
    endtask

    initial begin
        #(10 * MAXC);
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, s0, t0, len, nexp, gap;
        byte unsigned exp_q[$];

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tx_out", o1 === 1'b1, o1, 1'b1);
        chk("rst_busy", b1 === 1'b0, b1, 1'b0);
        chk("rst_ready", r1 === 1'b1, r1, 1'b1);
        chk("rst_done", dn1 === 1'b0, dn1, 1'b0);
        d1 = 8'hAA; v1 = 1'b1;
        tick();
        chk("rst_ignores_valid", r1 === 1'b1, r1, 1'b1);
        v1 = 1'b0; rst = 1'b0;
        tick();

        send1(8'h55, a);
        chk("lat_ready_low", r1 === 1'b0, r1, 1'b0);
        chk("lat_line_idle", o1 === 1'b1, o1, 1'b1);
        chk("lat_busy_idle", b1 === 1'b0, b1, 1'b0);
        tick();
        chk("lat_start_bit", o1 === 1'b0, o1, 1'b0);
        chk("lat_busy_high", b1 === 1'b1, b1, 1'b1);
        chk("lat_ready_back", r1 === 1'b1, r1, 1'b1);
        repeat (50) tick();
        decode(1, a, cyc, CPB, 1);
        chk("single_nframes", rx_b.size() === 1, rx_b.size(), 1);
        if (rx_b.size() > 0) begin
            chk("single_byte", rx_b[0] === 8'h55, rx_b[0], 8'h55);
            chk("single_ok", rx_ok[0] === 1'b1, rx_ok[0], 1'b1);
            chk("single_start", rx_s[0] === a + 1, rx_s[0], a + 1);
        end
        chk("single_busy_len", count_hi(0, a, cyc) === F1, count_hi(0, a, cyc), F1);
        chk("single_done_cnt", count_hi(1, a, cyc) === 1, count_hi(1, a, cyc), 1);
        chk("single_done_pos", done1[a + 1 + F1] === 1'b1, done1[a + 1 + F1], 1'b1);

        send1(8'hA3, a);
        repeat (1 + CPB * 3) tick();
        send1(8'h3C, a2);
        repeat (100) tick();
        decode(1, a, cyc, CPB, 1);
        chk("b2b_nframes", rx_b.size() === 2, rx_b.size(), 2);
        if (rx_b.size() > 1) begin
            chk("b2b_byte0", rx_b[0] === 8'hA3, rx_b[0], 8'hA3);
            chk("b2b_byte1", rx_b[1] === 8'h3C, rx_b[1], 8'h3C);
            chk("b2b_ok0", rx_ok[0] === 1'b1, rx_ok[0], 1'b1);
            chk("b2b_ok1", rx_ok[1] === 1'b1, rx_ok[1], 1'b1);
            chk("b2b_start0", rx_s[0] === a + 1, rx_s[0], a + 1);
            chk("b2b_gapless", rx_s[1] === a + 1 + F1, rx_s[1], a + 1 + F1);
            chk("b2b_ready_low", count_hi(2, a2, rx_s[1]) === 0, count_hi(2, a2, rx_s[1]), 0);
            chk("b2b_ready_back", rdy1[rx_s[1]] === 1'b1, rdy1[rx_s[1]], 1'b1);
        end

        len = 60 + $urandom_range(0, 80);
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        for (int off = 2 + F1; off < len; off += F1) exp_q.push_back(8'(off));
        t0 = cyc + 1;
        for (int k = 0; k < len; k++) begin
            d1 = 8'(k); v1 = 1'b1;
            tick();
        end
        v1 = 1'b0;
        repeat (2 * F1 + 20) tick();
        decode(1, t0, cyc, CPB, 1);
        chk("ovf_nframes", rx_b.size() === exp_q.size(), rx_b.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < rx_b.size(); j++) begin
            chk("ovf_byte", rx_b[j] === exp_q[j], rx_b[j], exp_q[j]);
            chk("ovf_ok", rx_ok[j] === 1'b1, rx_ok[j], 1'b1);
        end
        if (rx_s.size() > 0) chk("ovf_first_start", rx_s[0] === t0 + 1, rx_s[0], t0 + 1);

        exp_q.delete();
        t0 = cyc;
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(8'($urandom));
            gap = $urandom_range(0, 50);
            repeat (gap) tick();
            send1(exp_q[j], a);
        end
        repeat (2 * F1 + 40) tick();
        decode(1, t0, cyc, CPB, 1);
        chk("rnd_nframes", rx_b.size() === exp_q.size(), rx_b.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < rx_b.size(); j++) begin
            chk("rnd_byte", rx_b[j] === exp_q[j], rx_b[j], exp_q[j]);
            chk("rnd_ok", rx_ok[j] === 1'b1, rx_ok[j], 1'b1);
        end

        send1(8'hFF, a);
        send1(8'h12, a2);
        chk("abort_buffered", r1 === 1'b0, r1, 1'b0);
        s0 = a + 1;
        while (cyc < s0 + CPB * 4 + 1) tick();
        rst = 1'b1; d1 = 8'h77; v1 = 1'b1;
        tick();
        chk("abort_line", o1 === 1'b1, o1, 1'b1);
        chk("abort_ready", r1 === 1'b1, r1, 1'b1);
        chk("abort_busy", b1 === 1'b0, b1, 1'b0);
        chk("abort_done", dn1 === 1'b0, dn1, 1'b0);
        rst = 1'b0; v1 = 1'b0;
        t0 = cyc;
        repeat (3 * F1) tick();
        decode(1, t0, cyc, CPB, 1);
        chk("abort_silent", rx_b.size() === 0, rx_b.size(), 0);
        chk("abort_busy_after", count_hi(0, t0, cyc) === 0, count_hi(0, t0, cyc), 0);

        t0 = cyc;
        send2(8'h00);
        send2(8'hFF);
        send2(8'h5A);
        repeat (2 * F2 + 200) tick();
        decode(2, t0, cyc, CPB2, 2);
        chk("loop_nframes", rx_b.size() === 3, rx_b.size(), 3);
        if (rx_b.size() > 2) begin
            chk("loop_byte0", rx_b[0] === 8'h00, rx_b[0], 8'h00);
            chk("loop_byte1", rx_b[1] === 8'hFF, rx_b[1], 8'hFF);
            chk("loop_byte2", rx_b[2] === 8'h5A, rx_b[2], 8'h5A);
            chk("loop_ok0", rx_ok[0] === 1'b1, rx_ok[0], 1'b1);
            chk("loop_ok1", rx_ok[1] === 1'b1, rx_ok[1], 1'b1);
            chk("loop_ok2", rx_ok[2] === 1'b1, rx_ok[2], 1'b1);
            chk("loop_len01", (rx_s[1] - rx_s[0]) === F2, rx_s[1] - rx_s[0], F2);
            chk("loop_len12", (rx_s[2] - rx_s[1]) === F2, rx_s[2] - rx_s[1], F2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk50 cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits per frame; legal values 1 or 2.
REQ-003 clk50  input  1  system clock; one clock domain only, all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 tx_data  input  8  byte to transmit; sampled only on an accept cycle.
REQ-006 tx_valid  input  1  tx_data is valid this cycle.
REQ-007 tx_ready  output  1  holding buffer empty; a byte can be accepted.
REQ-008 tx_out  output  1  serial line; idles high.
REQ-009 tx_busy  output  1  a frame is on the line (start, data or stop bit).
REQ-010 tx_done  output  1  one-cycle pulse when the last stop bit of a frame completes.

Function
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1); no parity.
REQ-012 Each bit holds tx_out for exactly CLKS_PER_BIT cycles, so a 1-stop frame lasts exactly 10*CLKS_PER_BIT cycles.
REQ-013 Bit timing uses a 16-bit counter that counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-014 tx_out, tx_busy, tx_ready and tx_done are registered outputs with no combinational path from any input.
REQ-015 The design has a one-entry holding buffer (hold_data, hold_full) in front of the shift register.
REQ-016 tx_ready = !hold_full.
REQ-017 Accept means tx_valid && tx_ready on a rising edge; tx_data is captured into the holding buffer and hold_full is set.
REQ-018 If tx_valid is asserted while tx_ready is low, the byte is ignored; it is not queued or dropped silently into state.
REQ-019 State machine states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx_out = 1 and tx_busy = 0. If hold_full is set, on the next edge the FSM loads the shift register from hold_data, clears hold_full, moves to START, drives tx_out = 0 and zeroes the counter.
REQ-021 START: after CLKS_PER_BIT cycles, move to DATA with bit index 0 and drive bit 0.
REQ-022 DATA: after each bit period, advance the bit index. After bit index 7, move to STOP and drive tx_out = 1.
REQ-023 STOP: after STOP_BITS*CLKS_PER_BIT cycles, assert tx_done for one cycle, then:
  - if hold_full is set, load the shift register and go directly to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
REQ-024 Latency: a byte accepted at edge N into an empty buffer in IDLE gives hold_full = 1 after edge N, and tx_out falls and tx_busy rises at edge N+1.
REQ-025 Simultaneous accept and buffer unload on the same edge: the new byte is stored, hold_full stays 1, and no byte is lost.
REQ-026 A new byte can be accepted during any part of a frame, as soon as tx_ready is high; at most one byte waits.
REQ-027 tx_data and tx_valid changing in the middle of a frame have no effect on the frame being sent.
REQ-028 An undefined FSM encoding returns to IDLE on the next edge with tx_out = 1.

Reset
REQ-029 While rst = 1, on each rising edge:
  - tx_out = 1, tx_busy = 0, tx_done = 0;
  - hold_full = 0, tx_ready = 1;
  - FSM = IDLE, counter = 0, bit index = 0.
REQ-030 Reset asserted mid-frame aborts the frame. The line returns high on the next edge, and the buffered byte is discarded.
REQ-031 tx_valid is ignored on any edge where rst = 1.

Verification (directed, CLKS_PER_BIT = 4 unless stated)
REQ-032 Single byte: accept 0x55 in IDLE -> tx_out sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; tx_done pulses once at cycle 40 after start; tx_busy is high for exactly 40 cycles.
REQ-033 Back-to-back: accept 0xA3, then 0x3C while the first frame is in DATA -> second start bit begins on the edge immediately after the first stop bit ends; both bytes decode correctly; tx_ready is low from the second accept until the second frame starts.
REQ-034 Overflow: hold tx_valid high continuously with data incrementing from 0x00 -> only the bytes accepted while tx_ready = 1 are sent, in order, with no duplicates.
REQ-035 Reset mid-frame: assert rst at DATA bit 3 of 0xFF with a byte buffered -> tx_out = 1, tx_ready = 1, tx_busy = 0 on the next edge; nothing is transmitted afterwards until a new accept.
REQ-036 Loopback: CLKS_PER_BIT = 434, STOP_BITS = 2, tx_out wired to the team's 115200 UART receiver; send 0x00, 0xFF, 0x5A -> receiver reports exactly those bytes; each frame lasts 11*434 cycles.
